cell_op_sequencer: RTL
======================

Name: cell_op_sequencer

Overview:
- Control block that runs one image-level instruction through the cell processor datapath.
- On a start command it latches opcode and user input, raster-scans every legal 3x3 cell window of the source image, and issues one cell request per window over a valid/ready handshake.
- It credit-limits in-flight cells, counts in-order results back, generates the destination write address for each result pixel, and signals done when the last result retires.

Parameters:
IMG_W, 640, source image width in pixels
IMG_H, 480, source image height in pixels
CELL_N, 3, cell edge length; window origin range is 0..IMG_W-CELL_N by 0..IMG_H-CELL_N
MAX_INFLIGHT, 4, maximum issued-but-unreturned cells (1..15)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle command pulse, honoured only in IDLE
abort  in  1  terminate current instruction
opcode  in  4  opcodes_t, sampled with start
user_input  in  8  userInput_t, sampled with start
busy  out  1  high from accepted start until done/abort completes
done  out  1  one-cycle pulse, instruction complete
err  out  1  sticky illegal-opcode flag, cleared by next accepted start
cell_valid  out  1  cell request valid
cell_ready  in  1  cell processor accepts request
cell_x  out  10  window origin column
cell_y  out  9  window origin row
cell_opcode  out  4  latched opcode
cell_user  out  8  latched user input
res_valid  in  1  result pixel valid (in issue order, no backpressure)
res_pixel  in  24  pixel_t result
wr_en  out  1  destination write strobe
wr_x  out  10  destination column (0..IMG_W-CELL_N)
wr_y  out  9  destination row (0..IMG_H-CELL_N)
wr_pixel  out  24  registered res_pixel

Behaviour:
- Reset (async assert, sync release): state IDLE; busy=0, done=0, err=0, cell_valid=0, wr_en=0, all coordinate, opcode, user and pixel outputs 0; credit counter 0.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE -> ISSUE on start with opcode <= AVG (11). Latches opcode and user_input, zeroes issue and write coordinates, sets busy and clears err.
- IDLE with start and opcode > 11: set err, remain IDLE, busy stays 0.
- start outside IDLE is ignored.
- ISSUE:
  - cell_valid = 1 while inflight < MAX_INFLIGHT.
  - A transfer occurs when cell_valid && cell_ready; the coordinates advance on that edge.
  - Coordinates advance x first; at x = IMG_W-CELL_N, x wraps to 0 and y increments.
  - The transfer at (IMG_W-CELL_N, IMG_H-CELL_N) moves the FSM to DRAIN and drops cell_valid in the next cycle.
  - cell_x, cell_y, cell_opcode and cell_user are stable while cell_valid && !cell_ready.
- Credit counter:
  - +1 on a transfer, -1 on res_valid; both in the same cycle leave it unchanged.
  - When at MAX_INFLIGHT, a same-cycle res_valid lets cell_valid assert in the following cycle, not combinationally.
- Result path:
  - On res_valid: next cycle wr_en = 1, wr_pixel = res_pixel, wr_x/wr_y = write counter.
  - The write counter advances with the same wrap rule as the issue coordinates.
  - Write latency is 1 cycle.
  - res_valid with a zero credit counter is a protocol error: ignored, counter does not underflow.
- DRAIN -> DONE when the credit counter is 0 and the final wr_en has been issued.
- DONE: done = 1 for one cycle, busy = 0, then IDLE.
- abort (any non-IDLE state):
  - Drop cell_valid next cycle and enter DRAIN.
  - Continue retiring in-flight results so the datapath empties, then DONE.
  - abort in IDLE has no effect; abort and start together in IDLE: abort wins, no run.
- Total cells per instruction: (IMG_W-CELL_N+1)*(IMG_H-CELL_N+1) = 638*478 = 304964 with defaults.

Optional Feature:
- Macro: CELL_SEQ_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt [31:0], counting cycles in ISSUE where cell_valid && !cell_ready.
  - Also counts cycles in ISSUE where cell_valid = 0 because credits are exhausted.
  - Cleared on accepted start, saturates at all ones, holds after done.
- When undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package CellProcessingPkg: opcodes_t, userInput_t, pixel_t, cellN.
- Shared package ImageProcessingPkg: imageWidth, imageHeighth, and a new seqState_t enum {IDLE, ISSUE, DRAIN, DONE}.
- Sub-module raster_counter, instantiated twice (issue and write side). Inputs: advance, clear. Outputs: x, y, last, where last = (x==IMG_W-CELL_N && y==IMG_H-CELL_N). Parameterised by IMG_W, IMG_H, CELL_N.

Test Plan:
- ADD run, cell_ready=1, 2-cycle result latency, IMG_W=6 IMG_H=5 -> 12 requests ordered (0,0),(1,0),(2,0),(3,0),(0,1)..(3,2); 12 wr_en with matching coords; done 1 cycle after last wr_en.
- cell_ready held 0 for 5 cycles at cell (2,1) -> cell_x=2, cell_y=1 stable throughout; no duplicate or skipped coordinate.
- MAX_INFLIGHT=2, results withheld -> cell_valid drops after 2 transfers; one res_valid -> exactly one more transfer.
- start with opcode=14 -> err=1, busy=0, no cell_valid; next start with opcode SUBI -> err clears, run proceeds.
- abort after 5 transfers with 2 in flight -> no further transfers; 2 wr_en retire; done pulses; then IDLE.
- rst_n asserted mid-ISSUE -> all outputs 0 immediately (async); after release, a new start runs cleanly from (0,0).

Source files
------------

// File: rtl/cell_processing_pkg.sv
// Shared cell-processor types: opcodes, user input, pixel format and the
// cell edge length. Imported by the sequencer and its raster counter.
package CellProcessingPkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_DIV  = 4'd3,
        OP_ADDI = 4'd4,
        OP_SUBI = 4'd5,
        OP_MULI = 4'd6,
        OP_DIVI = 4'd7,
        OP_AND  = 4'd8,
        OP_OR   = 4'd9,
        OP_XOR  = 4'd10,
        OP_AVG  = 4'd11
    } opcodes_t;

    typedef logic [7:0]  userInput_t;
    typedef logic [23:0] pixel_t;

    localparam int cellN = 3;

    // Opcodes above AVG have no datapath meaning.
    function automatic logic opcode_legal(input logic [3:0] op);
        return op <= 4'(OP_AVG);
    endfunction

endpackage

// File: rtl/image_processing_pkg.sv
// Shared image geometry and the sequencer state encoding.
package ImageProcessingPkg;

    localparam int imageWidth   = 640;
    localparam int imageHeighth = 480;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seqState_t;

endpackage

// File: rtl/cell_op_sequencer_raster.sv
// raster_counter: walks every legal cell-window origin in raster order
// (x first, then y). Used once for request issue and once for result writes.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       return to origin (0,0); has priority over advance
//   advance     step to the next origin; wraps to (0,0) after the last one
//   x, y        current origin
//   last        current origin is (IMG_W-CELL_N, IMG_H-CELL_N)
module raster_counter #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int CELL_N = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       advance,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic       last
);

    localparam logic [9:0] X_LAST = 10'(IMG_W - CELL_N);
    localparam logic [8:0] Y_LAST = 9'(IMG_H - CELL_N);

    logic [9:0] x_q, x_d;
    logic [8:0] y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear) begin
            x_d = '0;
            y_d = '0;
        end else if (advance) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 9'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign last = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/cell_op_sequencer.sv
// cell_op_sequencer: runs one image-level instruction through the cell
// datapath. Issues one request per legal 3x3 window origin, credit-limits
// in-flight cells, writes each returned pixel to its destination coordinate
// and pulses done once the last result has retired.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, abort               command pulse (IDLE only) / terminate run
//   opcode, user_input         instruction operands, sampled with start
//   busy, done, err            run status; err is sticky until next accepted start
//   cell_valid/cell_ready      request handshake; cell_x/y/opcode/user payload
//   res_valid, res_pixel       in-order results, no backpressure
//   wr_en, wr_x, wr_y, wr_pixel destination write port, one cycle after res_valid
//   stall_cnt                  only with CELL_SEQ_STALL_CNT_EN defined
// Handshake: a request transfers on any rising edge where cell_valid and
// cell_ready are both high; while cell_valid is high and cell_ready is low the
// payload holds. cell_valid only drops without a transfer on abort.
module cell_op_sequencer
    import CellProcessingPkg::*;
    import ImageProcessingPkg::*;
#(
    parameter int IMG_W        = imageWidth,
    parameter int IMG_H        = imageHeighth,
    parameter int CELL_N       = cellN,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [3:0]  opcode,
    input  logic [7:0]  user_input,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cell_valid,
    input  logic        cell_ready,
    output logic [9:0]  cell_x,
    output logic [8:0]  cell_y,
    output logic [3:0]  cell_opcode,
    output logic [7:0]  cell_user,
    input  logic        res_valid,
    input  logic [23:0] res_pixel,
`ifdef CELL_SEQ_STALL_CNT_EN
    output logic [31:0] stall_cnt,
`endif
    output logic        wr_en,
    output logic [9:0]  wr_x,
    output logic [8:0]  wr_y,
    output logic [23:0] wr_pixel
);

    localparam logic [3:0] MAX_CR = 4'(MAX_INFLIGHT);

    seqState_t  state_q, state_d;
    logic [3:0] credit_q, credit_d;
    logic       busy_q, done_q, err_q, cell_valid_q, wr_en_q;
    logic [3:0] opcode_q;
    userInput_t user_q;
    pixel_t     wr_pixel_q;
    logic [9:0] wr_x_q;
    logic [8:0] wr_y_q;

    logic       xfer, res_take, start_ok, start_bad;
    logic [9:0] iss_x, wc_x;
    logic [8:0] iss_y, wc_y;
    logic       iss_last, unused_wr_last;

    assign xfer      = cell_valid_q && cell_ready;
    // A result with no credit outstanding cannot belong to any request.
    assign res_take  = res_valid && (credit_q != 4'd0);
    // abort beats a simultaneous start in IDLE.
    assign start_ok  = (state_q == IDLE) && start && !abort && opcode_legal(opcode);
    assign start_bad = (state_q == IDLE) && start && !abort && !opcode_legal(opcode);

    raster_counter #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CELL_N(CELL_N)) u_issue_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (start_ok),
        .advance (xfer),
        .x       (iss_x),
        .y       (iss_y),
        .last    (iss_last)
    );

    raster_counter #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CELL_N(CELL_N)) u_write_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (start_ok),
        .advance (res_take),
        .x       (wc_x),
        .y       (wc_y),
        .last    (unused_wr_last)
    );

    always_comb begin
        credit_d = credit_q;
        if (xfer && !res_take) begin
            credit_d = credit_q + 4'd1;
        end else if (!xfer && res_take) begin
            credit_d = credit_q - 4'd1;
        end
    end

    // In DRAIN, credit_q reaching zero means the final result was taken on
    // the previous edge, so its wr_en is already out; DONE follows next edge.
    // abort in DONE is moot: the instruction has already completed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = ISSUE;
            ISSUE:   if (abort || (xfer && iss_last)) state_d = DRAIN;
            DRAIN:   if (credit_q == 4'd0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from next-state values, so a credit freed by a
    // same-cycle result reopens cell_valid only on the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            credit_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            cell_valid_q <= 1'b0;
            wr_en_q      <= 1'b0;
            opcode_q     <= '0;
            user_q       <= '0;
            wr_pixel_q   <= '0;
            wr_x_q       <= '0;
            wr_y_q       <= '0;
        end else begin
            state_q      <= state_d;
            credit_q     <= credit_d;
            busy_q       <= (state_d == ISSUE) || (state_d == DRAIN);
            done_q       <= (state_d == DONE);
            cell_valid_q <= (state_d == ISSUE) && (credit_d < MAX_CR);
            wr_en_q      <= res_take;
            if (res_take) begin
                wr_pixel_q <= res_pixel;
                wr_x_q     <= wc_x;
                wr_y_q     <= wc_y;
            end
            if (start_ok) begin
                opcode_q <= opcode;
                user_q   <= user_input;
                err_q    <= 1'b0;
            end else if (start_bad) begin
                err_q    <= 1'b1;
            end
        end
    end

`ifdef CELL_SEQ_STALL_CNT_EN
    logic [31:0] stall_q;

    // Counts ISSUE cycles lost either to downstream backpressure or to
    // exhausted credits; saturates and holds after the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (start_ok) begin
            stall_q <= '0;
        end else if ((state_q == ISSUE) && (stall_q != '1) &&
                     ((cell_valid_q && !cell_ready) ||
                      (!cell_valid_q && (credit_q >= MAX_CR)))) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign cell_valid  = cell_valid_q;
    assign cell_x      = iss_x;
    assign cell_y      = iss_y;
    assign cell_opcode = opcode_q;
    assign cell_user   = user_q;
    assign wr_en       = wr_en_q;
    assign wr_x        = wr_x_q;
    assign wr_y        = wr_y_q;
    assign wr_pixel    = wr_pixel_q;

endmodule
